sm_seq_param: RTL and testbench

Parametrised Moore sequencer that generalises the four-state, single-branch control FSM. It supports:
- N states;
- a configurable branch (skip) point;
- a per-state dwell time;
- an enable/hold input;
- explicit illegal-state recovery;
- selectable registered or combinational output.

It sits between a control source and downstream datapath blocks that need a stepped state index.

---
 rtl/sm_pkg.sv | 35 +++
 rtl/sm_dwell_counter.sv | 50 +++++
 rtl/sm_seq_param.sv | 123 ++++++++++++
 tb/tb_sm_seq_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared helpers for the parametrised sequencer: width math and parameter legality.
package sm_pkg;

    // Ceiling log2 for positive values; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Width of the state index; at least one bit so a 1-bit port is always legal.
    function automatic int state_width(input int num_states);
        int w;
        w = clog2(num_states);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // True when the sequencer parameter set describes a realisable machine.
    function automatic bit params_ok(
        input int num_states,
        input int skip_from,
        input int skip_to,
        input int dwell
    );
        return (num_states >= 32'sd2) &&
               (skip_from >= 32'sd0) &&
               (skip_from < skip_to) &&
               (skip_to <= num_states - 32'sd1) &&
               (dwell >= 32'sd1);
    endfunction

endpackage

// File: rtl/sm_dwell_counter.sv
// Dwell counter: counts enabled cycles in the current state and flags the
// cycle on which the state may advance.
module sm_dwell_counter
    import sm_pkg::*;
#(
    parameter int DWELL = 1
)(
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clr,
    output logic done
);

    generate
        if (DWELL == 1) begin : g_single
            // Every enabled cycle is an advance, so no storage is needed.
            logic tie_unused_s;
            assign tie_unused_s = clk ^ reset_n ^ clr;
            assign done         = enable;
        end else begin : g_count
            localparam int            CW       = clog2(DWELL);
            localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
            localparam logic [CW-1:0] CNT_ONE  = CW'(1);
            localparam logic [CW-1:0] CNT_ZERO = CW'(0);

            logic [CW-1:0] cnt_r;

            assign done = enable && (cnt_r == CNT_LAST);

            // Count enabled cycles, restart on advance or clear, hold when disabled.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_r <= CNT_ZERO;
                end else if (clr) begin
                    cnt_r <= CNT_ZERO;
                end else if (enable) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sm_seq_param.sv
// Parametrised Moore sequencer: N states, one branch point, per-state dwell,
// enable/hold, illegal-encoding recovery and selectable output register.
module sm_seq_param
    import sm_pkg::*;
#(
    parameter int  NUM_STATES = 4,
    parameter int  SKIP_FROM  = 1,
    parameter int  SKIP_TO    = 3,
    parameter int  DWELL      = 1,
    parameter int  OUT_REG    = 0,
    localparam int W          = state_width(NUM_STATES)
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         control,
    output logic [W-1:0] y,
    output logic         wrap,
    output logic         state_err
);

    localparam int           WE       = W + 1;
    localparam logic [W-1:0] ST_FIRST = {W{1'b0}};
    localparam logic [W-1:0] ST_ONE   = W'(1);
    localparam logic [W-1:0] ST_LAST  = W'(NUM_STATES - 1);
    localparam logic [W-1:0] SKIP_SRC = W'(SKIP_FROM);
    localparam logic [W-1:0] SKIP_DST = W'(SKIP_TO);
    localparam logic [W:0]   ST_LIMIT = WE'(NUM_STATES);

    generate
        if (!params_ok(NUM_STATES, SKIP_FROM, SKIP_TO, DWELL)) begin : g_bad_params
            $error("sm_seq_param: illegal NUM_STATES/SKIP_FROM/SKIP_TO/DWELL combination");
        end
    endgenerate

    logic [W-1:0] state_r;
    logic [W-1:0] state_nxt_s;
    logic         illegal_s;
    logic         advance_s;
    logic         wrap_nxt_s;
    logic         err_nxt_s;
    logic         wrap_r;
    logic         err_r;

    // Encodings at or above NUM_STATES only arise from an upset.
    assign illegal_s = ({1'b0, state_r} >= ST_LIMIT);

    sm_dwell_counter #(
        .DWELL   (DWELL)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clr     (illegal_s),
        .done    (advance_s)
    );

    // Next-state and pulse decode; illegal encodings always fall to recovery.
    always_comb begin
        state_nxt_s = state_r;
        wrap_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        case ({illegal_s, advance_s})
            2'b00: begin
                state_nxt_s = state_r;
            end
            2'b01: begin
                if (state_r == SKIP_SRC) begin
                    if (control) begin
                        state_nxt_s = SKIP_DST;
                    end else begin
                        state_nxt_s = SKIP_SRC + ST_ONE;
                    end
                end else if (state_r == ST_LAST) begin
                    state_nxt_s = ST_FIRST;
                    wrap_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = state_r + ST_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_FIRST;
                err_nxt_s   = 1'b1;
            end
        endcase
    end

    // Current-state register and one-cycle status pulses; reset overrides recovery.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_FIRST;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wrap_r  <= wrap_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign wrap      = wrap_r;
    assign state_err = err_r;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] y_r;

            // Dedicated output flop loaded with the next state, so y tracks state_r glitch-free.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    y_r <= ST_FIRST;
                end else begin
                    y_r <= state_nxt_s;
                end
            end

            assign y = y_r;
        end else begin : g_out_comb
            assign y = state_r;
        end
    endgenerate

endmodule

// File: tb/tb_sm_seq_param.sv
// Randomised self-checking bench for sm_seq_param: four parameterisations
// share stimulus and are compared every cycle against a behavioural model.
module tb_sm_seq_param;

    localparam int P_N  [4] = '{4, 6, 5, 5};
    localparam int P_SF [4] = '{1, 2, 1, 1};
    localparam int P_ST [4] = '{3, 5, 3, 3};
    localparam int P_DW [4] = '{1, 3, 2, 2};

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       control;
    logic [1:0] y0;
    logic [2:0] y1, y2, y3;
    logic       wrap0, wrap1, wrap2, wrap3;
    logic       err0, err1, err2, err3;

    int n_cmp;
    int n_bad;
    int cyc;
    int m_st   [4];
    int m_dw   [4];
    int m_wrap [4];
    int m_err  [4];

    sm_seq_param #(.NUM_STATES(4), .SKIP_FROM(1), .SKIP_TO(3), .DWELL(1), .OUT_REG(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .y(y0), .wrap(wrap0), .state_err(err0)
    );

    sm_seq_param #(.NUM_STATES(6), .SKIP_FROM(2), .SKIP_TO(5), .DWELL(3), .OUT_REG(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .y(y1), .wrap(wrap1), .state_err(err1)
    );

    sm_seq_param #(.NUM_STATES(5), .SKIP_FROM(1), .SKIP_TO(3), .DWELL(2), .OUT_REG(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .y(y2), .wrap(wrap2), .state_err(err2)
    );

    sm_seq_param #(.NUM_STATES(5), .SKIP_FROM(1), .SKIP_TO(3), .DWELL(2), .OUT_REG(1)) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .control(control),
        .y(y3), .wrap(wrap3), .state_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: one clock edge of a sequencer described by table entry i.
    task automatic model_step(input int i, input bit rstn, input bit en, input bit ctl);
        m_wrap[i] = 0;
        m_err[i]  = 0;
        if (!rstn) begin
            m_st[i] = 0;
            m_dw[i] = 0;
        end else if (m_st[i] >= P_N[i]) begin
            m_st[i]  = 0;
            m_dw[i]  = 0;
            m_err[i] = 1;
        end else if (en) begin
            if (m_dw[i] < P_DW[i] - 1) begin
                m_dw[i] = m_dw[i] + 1;
            end else begin
                m_dw[i] = 0;
                if (m_st[i] == P_SF[i]) begin
                    m_st[i] = ctl ? P_ST[i] : P_SF[i] + 1;
                end else if (m_st[i] == P_N[i] - 1) begin
                    m_st[i]   = 0;
                    m_wrap[i] = 1;
                end else begin
                    m_st[i] = m_st[i] + 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [31:0] yv, input logic wv, input logic ev);
        chk($sformatf("dut%0d.y c%0d", i, cyc), yv, m_st[i]);
        chk($sformatf("dut%0d.wrap c%0d", i, cyc), {31'd0, wv}, m_wrap[i]);
        chk($sformatf("dut%0d.state_err c%0d", i, cyc), {31'd0, ev}, m_err[i]);
    endtask

    // Drive inputs just after an edge, clock once, then compare all four DUTs.
    task automatic cycle(input bit rstn, input bit en, input bit ctl);
        reset_n = rstn;
        enable  = en;
        control = ctl;
        @(posedge clk);
        for (int i = 0; i < 4; i++) model_step(i, rstn, en, ctl);
        #1;
        cyc = cyc + 1;
        check_dut(0, 32'(y0), wrap0, err0);
        check_dut(1, 32'(y1), wrap1, err1);
        check_dut(2, 32'(y2), wrap2, err2);
        check_dut(3, 32'(y3), wrap3, err3);
    endtask

    // Upset the N=5 machines into encoding 7 for one cycle, then clock with the given inputs.
    task automatic inject(input bit rstn, input bit en, input bit ctl);
        #1;
        force dut2.state_r = 3'd7;
        force dut3.state_r = 3'd7;
        #1;
        release dut2.state_r;
        release dut3.state_r;
        m_st[2] = 7;
        m_st[3] = 7;
        chk($sformatf("dut2.illegal_y c%0d", cyc), 32'(y2), 32'd7);
        cycle(rstn, en, ctl);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        control = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_st[i]   = 0;
            m_dw[i]   = 0;
            m_wrap[i] = 0;
            m_err[i]  = 0;
        end

        // Reset state, then free-run without skipping.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (40) cycle(1'b1, 1'b1, 1'b0);

        // Always skipping.
        cycle(1'b0, 1'b1, 1'b1);
        repeat (30) cycle(1'b1, 1'b1, 1'b1);

        // Enable toggling every cycle: dwell must accumulate across holds.
        cycle(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) cycle(1'b1, (k % 2) == 0, 1'b0);

        // Reset pulse while the 6-state machine sits mid-dwell in ST2.
        cycle(1'b0, 1'b1, 1'b0);
        repeat (7) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b1, 1'b0);

        // Illegal-encoding recovery: enabled, disabled, and coincident with reset.
        inject(1'b1, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b1);
        inject(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        inject(1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b0);

        // Random traffic with occasional resets and upsets.
        for (int k = 0; k < 400; k++) begin
            if ((k % 60) == 30) begin
                inject($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            end else begin
                cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
